// File: rtl/jtcontra_gfxrom_arb.sv
// Round-robin SDRAM read arbiter for the two Contra graphics ROM ports.
// Define JTCONTRA_ARB_CACHE_EN to keep latched words valid across cs drops.
module jtcontra_gfxrom_arb #(
  parameter int AW = 18,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] gfx1_addr,
  input  logic          gfx1_cs,
  output logic [DW-1:0] gfx1_data,
  output logic          gfx1_ok,
  input  logic [AW-1:0] gfx2_addr,
  input  logic          gfx2_cs,
  output logic [DW-1:0] gfx2_data,
  output logic          gfx2_ok,
  output logic [AW:0]   sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          sdram_rdy,
  input  logic [DW-1:0] sdram_din
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_ACK  = 2'd1;
  localparam logic [1:0] WAIT_DATA = 2'd2;

  logic [1:0]    st;
  logic [AW-1:0] tag1, tag2;
  logic [DW-1:0] dat1, dat2;
  logic          val1, val2;
  logic          last;
  logic          hit1, hit2;
  logic          need1, need2;
  logic          win;
  logic          sel;
  logic          fill;
  logic          busy1, busy2;

  assign hit1  = val1 && (tag1 == gfx1_addr);
  assign hit2  = val2 && (tag2 == gfx2_addr);
  assign need1 = gfx1_cs && !hit1;
  assign need2 = gfx2_cs && !hit2;

  assign gfx1_ok   = gfx1_cs && hit1;
  assign gfx2_ok   = gfx2_cs && hit2;
  assign gfx1_data = dat1;
  assign gfx2_data = dat2;

  // On a tie the requester not served last wins
  assign win = (need1 && need2) ? ~last : need2;
  assign sel = sdram_addr[AW];

  // Ack and rdy together in WAIT_ACK count as a completed read
  assign fill = ((st == WAIT_ACK) && sdram_ack && sdram_rdy)
             || ((st == WAIT_DATA) && sdram_rdy);

  assign busy1 = (st != IDLE) && !sel;
  assign busy2 = (st != IDLE) && sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      last       <= 1'b1;
    end else begin
      unique case (st)
        IDLE: begin
          if (need1 || need2) begin
            sdram_addr <= {win, win ? gfx2_addr : gfx1_addr};
            sdram_req  <= 1'b1;
            st         <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            st        <= sdram_rdy ? IDLE : WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (sdram_rdy) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
      if (fill) last <= sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag1 <= '0;
      dat1 <= '0;
      val1 <= 1'b0;
    end else if (fill && !sel) begin
      tag1 <= sdram_addr[AW-1:0];
      dat1 <= sdram_din;
      val1 <= 1'b1;
    end
`ifdef JTCONTRA_ARB_CACHE_EN
`else
    else if (!gfx1_cs && !busy1) begin
      val1 <= 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag2 <= '0;
      dat2 <= '0;
      val2 <= 1'b0;
    end else if (fill && sel) begin
      tag2 <= sdram_addr[AW-1:0];
      dat2 <= sdram_din;
      val2 <= 1'b1;
    end
`ifdef JTCONTRA_ARB_CACHE_EN
`else
    else if (!gfx2_cs && !busy2) begin
      val2 <= 1'b0;
    end
`endif
  end

`ifdef JTCONTRA_ARB_CACHE_EN
  logic unused_busy;
  assign unused_busy = busy1 ^ busy2;
`endif

endmodule

// File: doc/jtcontra_gfxrom_arb.md
# jtcontra_gfxrom_arb

Shares one SDRAM read port between the two graphics chip ROM interfaces (gfx1 and gfx2) of the Contra/Combat School video subsystem. Each requester sees a private `addr/cs/data/ok` ROM slot. The arbiter holds a one-entry tagged data latch per requester, issues SDRAM reads in round-robin order, and returns data with a valid `ok` flag. It sits between the video block's `gfx1_*`/`gfx2_*` ROM ports and the SDRAM controller.

## Interface
Parameters:
- `AW`, 18, requester address width (16-bit words).
- `DW`, 16, data width.

Ports:
- `clk`  in  1  system clock (48 MHz); the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `gfx1_addr`  in  AW  requester 1 word address.
- `gfx1_cs`  in  1  requester 1 read request.
- `gfx1_data`  out  DW  requester 1 data.
- `gfx1_ok`  out  1  `gfx1_data` is valid for the current `gfx1_addr`.
- `gfx2_addr`, `gfx2_cs`, `gfx2_data`, `gfx2_ok`: same as requester 1, for requester 2.
- `sdram_addr`  out  AW+1  `{sel, addr}`; `sel`=0 for gfx1, 1 for gfx2.
- `sdram_req`  out  1  read request, held until acknowledged.
- `sdram_ack`  in  1  one-cycle pulse: request accepted.
- `sdram_rdy`  in  1  one-cycle pulse: `sdram_din` valid.
- `sdram_din`  in  DW  read data.

## Operation
- Per requester i, the block keeps these registers: `tag_i[AW-1:0]`, `dat_i[DW-1:0]`, `val_i`.
- `hit_i = val_i & (tag_i == addr_i)`.
- `need_i = cs_i & ~hit_i`.
- `ok_i = cs_i & hit_i` (combinational).
- `data_i = dat_i`.
- FSM states:
  - IDLE:
    - If any `need_i`, pick the winner: the only needer, or, if both need, the one not served last.
    - Latch `{sel, addr_sel}` into `sdram_addr`, set `sdram_req`=1, go to WAIT_ACK.
  - WAIT_ACK:
    - On `sdram_ack`: clear `sdram_req`, go to WAIT_DATA.
    - If `sdram_rdy` arrives in the same cycle as `sdram_ack`, treat it as both events and complete the read (go to IDLE).
  - WAIT_DATA:
    - On `sdram_rdy`: `dat_sel`←`sdram_din`, `tag_sel`←latched address, `val_sel`←1, `last`←sel, go to IDLE.
- The write tag is always the address latched at issue time. If the requester's address changed during the fetch, `ok` stays low after completion and a new fetch is issued from IDLE.
- `sdram_addr` is stable from the `sdram_req` rising edge until `sdram_ack`.
- `sdram_rdy` or `sdram_ack` pulses seen in IDLE are ignored.
- Requests are never aborted. `cs` falling mid-fetch still completes the fetch and writes the latch.

## Timing
- Reset values:
  - `sdram_req`=0, `sdram_addr`=0.
  - `val_1`=`val_2`=0; `tag_i`=0, `dat_i`=0.
  - `last`=1, so gfx1 wins the first tie.
  - State = IDLE.
  - `gfx*_ok`=0; `gfx*_data`=0.
- Reset asserted mid-operation returns to IDLE with `sdram_req`=0 on the next edge. A late `sdram_rdy` is then discarded.
- Miss latency: `need` sampled at edge 0 gives `sdram_req`=1 after edge 0. With ack at edge A and rdy at edge R≥A, `ok` is high after edge R, i.e. one cycle after the rdy pulse.
- Hit latency: `ok` follows `cs`/`addr` combinationally (0 cycles).
- Back-to-back: after completion the FSM spends one cycle in IDLE, so the next `sdram_req` asserts one cycle after completion.
- Fairness: with both requesters continuously missing, grants alternate 1,2,1,2…

## Configuration
- `JTCONTRA_ARB_CACHE_EN` defined:
  - `val_i` survives `cs_i` deassertion.
  - Re-asserting `cs_i` at the cached address gives `ok` immediately with no SDRAM access.
- `JTCONTRA_ARB_CACHE_EN` undefined:
  - `val_i` clears on the cycle after `cs_i` is sampled low, except while requester i's own fetch is in flight.
  - Every new `cs` assertion costs one SDRAM read, even at an unchanged address.

## Test plan
- Reset, then gfx1 `cs`=1, addr=0x00123; SDRAM acks after 2 cycles and returns 0xBEEF 3 cycles later → `sdram_addr`=0x00123, one request, `gfx1_data`=0xBEEF, `gfx1_ok`=1 one cycle after rdy; `gfx2_ok`=0 throughout.
- Both requesters miss in the same cycle (gfx1 0x10, gfx2 0x20) → first issue `sdram_addr`=0x00010, second 0x40020; four consecutive mutual misses are granted 1,2,1,2.
- gfx1 changes addr 0x10→0x11 between ack and rdy → latch tagged 0x10, `gfx1_ok` stays 0, second request issued for 0x11, `ok` rises after its rdy.
- `rst` pulsed while in WAIT_DATA, followed by an `sdram_rdy` with 0x5555 → `sdram_req`=0, `val`=0, data not captured, `ok`=0.
- `sdram_ack` and `sdram_rdy` in the same cycle → read completes and `ok`=1 the next cycle, with no hang in WAIT_DATA.
- Drop gfx2 `cs` after a filled read, then re-raise it at the same address → with `JTCONTRA_ARB_CACHE_EN` defined, `ok`=1 the same cycle and no `sdram_req`; with it undefined, a new `sdram_req` is issued.
